// File: rtl/mux_seq_pkg.sv
// Shared constants for the mux select sequencer.
// State encoding and default widths.
package mux_seq_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int SEL_W_DEF   = 2;
  localparam int DWELL_W_DEF = 8;

endpackage

// File: rtl/mux_next_ch.sv
// Circular priority search for the next enabled
// channel strictly above cur (may return cur itself).
module mux_next_ch
  import mux_seq_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [SEL_W-1:0]    cur,
  input  logic [2**SEL_W-1:0] mask,
  output logic [SEL_W-1:0]    nxt,
  output logic                wrap,
  output logic                none
);

  localparam int N_CH = 2**SEL_W;

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int k = 1; k <= N_CH; k++) begin
      idx = cur + SEL_W'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  assign none = ~|mask;
  assign wrap = found && (nxt <= cur);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer for the 4:1 mux:
// dwell per channel, capture y, frame pulse on wrap.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [2**SEL_W-1:0] ch_mask,
  input  logic                y,
  output logic [SEL_W-1:0]    s,
  output logic                s_valid,
  output logic [2**SEL_W-1:0] sample,
  output logic                frame_done
);

  logic [0:0]         state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;

  logic [SEL_W-1:0] srch_cur;
  logic [SEL_W-1:0] nxt;
  logic             wrap;
  logic             none;
  logic             last;

  // From IDLE, searching above the top index yields the lowest set bit.
  assign srch_cur = (state == ST_IDLE) ?
                    {SEL_W{1'b1}} : s;

  assign last = (cnt == dwell_q);

  mux_next_ch #(
    .SEL_W (SEL_W)
  ) u_next (
    .cur  (srch_cur),
    .mask (ch_mask),
    .nxt  (nxt),
    .wrap (wrap),
    .none (none)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      s          <= '0;
      s_valid    <= 1'b0;
      sample     <= '0;
      frame_done <= 1'b0;
      cnt        <= '0;
      dwell_q    <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (en && !none) begin
            state   <= ST_RUN;
            s       <= nxt;
            cnt     <= '0;
            dwell_q <= dwell;
            s_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state   <= ST_IDLE;
            s_valid <= 1'b0;
          end else if (!last) begin
            cnt <= cnt + 1'b1;
          end else begin
            sample[s] <= y;
            if (none) begin
              state   <= ST_IDLE;
              s_valid <= 1'b0;
            end else begin
              s          <= nxt;
              cnt        <= '0;
              dwell_q    <= dwell;
              frame_done <= wrap;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomized bench for mux_sel_sequencer against a
// behavioural countdown model, plus directed cases.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] dwell = 8'd0;
  logic [3:0] ch_mask = 4'd0;
  logic       y;
  logic [1:0] s;
  logic       s_valid;
  logic [3:0] sample;
  logic       frame_done;

  logic [3:0] mux_i = 4'b1100;

  assign y = mux_i[s];

  always #5 clk = ~clk;

  mux_sel_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dwell      (dwell),
    .ch_mask    (ch_mask),
    .y          (y),
    .s          (s),
    .s_valid    (s_valid),
    .sample     (sample),
    .frame_done (frame_done)
  );

  bit         m_run;
  int         m_s;
  int         m_left;
  logic [3:0] m_sample;
  bit         m_fd;
  int         errors = 0;
  int         checks = 0;

  function automatic int lowest(input logic [3:0] m);
    int r = -1;
    for (int i = 0; i < 4; i++)
      if (r < 0 && m[i]) r = i;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int next_above(input int cur,
                                    input logic [3:0] m);
    int r = -1;
    for (int d = 1; d <= 4; d++)
      if (r < 0 && m[(cur + d) % 4]) r = (cur + d) % 4;
    return (r < 0) ? cur : r;
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_s = 0;
    m_left = 0;
    m_sample = 4'd0;
    m_fd = 0;
  endtask

  // m_left counts the cycles still to go in the current dwell
  task automatic model_step();
    int n;
    m_fd = 0;
    if (!m_run) begin
      if (en && ch_mask != 4'd0) begin
        m_run = 1;
        m_s = lowest(ch_mask);
        m_left = int'(dwell);
      end
    end else if (!en) begin
      m_run = 0;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      m_sample[m_s] = mux_i[m_s];
      if (ch_mask == 4'd0) begin
        m_run = 0;
      end else begin
        n = next_above(m_s, ch_mask);
        m_fd = (n <= m_s);
        m_s = n;
        m_left = int'(dwell);
      end
    end
  endtask

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("s", int'(s), m_s);
    chk("s_valid", int'(s_valid), int'(m_run));
    chk("sample", int'(sample), int'(m_sample));
    chk("frame_done", int'(frame_done), int'(m_fd));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_s", int'(s), 0);
    chk("rst_valid", int'(s_valid), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_fd", int'(frame_done), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // full sweep, dwell=3
    ch_mask = 4'b1111;
    dwell = 8'd3;
    en = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 1) chk("sweep_s0", int'(s), 0);
      if (c == 5) chk("sweep_s1", int'(s), 1);
      if (c == 13) chk("sweep_s3", int'(s), 3);
      if (c == 16) chk("sweep_nofd", int'(frame_done), 0);
      if (c == 17) begin
        chk("sweep_fd", int'(frame_done), 1);
        chk("sweep_s_wrap", int'(s), 0);
        chk("sweep_sample", int'(sample), 4'b1100);
      end
      if (c == 18) chk("sweep_fd_clr", int'(frame_done), 0);
    end
    // mid-dwell reset while s=2
    chk("pre_rst_s", int'(s), 2);
    do_reset();

    // sparse mask, dwell=0
    ch_mask = 4'b1010;
    dwell = 8'd0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) chk("sparse_s1", int'(s), 1);
      if (c == 2) chk("sparse_s3", int'(s), 3);
      if (c == 3) begin
        chk("sparse_fd", int'(frame_done), 1);
        chk("sparse_sample", int'(sample), 4'b1000);
      end
    end
    do_reset();

    // mask change mid-dwell
    ch_mask = 4'b1111;
    dwell = 8'd2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) ch_mask = 4'b0100;
      if (c == 3) chk("mid_hold_s0", int'(s), 0);
      if (c == 4) begin
        chk("mid_s2", int'(s), 2);
        chk("mid_nofd", int'(frame_done), 0);
      end
      if (c == 7) chk("mid_fd", int'(frame_done), 1);
      if (c == 10) chk("mid_fd2", int'(frame_done), 1);
    end
    do_reset();

    // stop and restart
    ch_mask = 4'b1111;
    dwell = 8'd1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 5) en = 1'b0;
      if (c == 6) begin
        chk("stop_s", int'(s), 2);
        chk("stop_valid", int'(s_valid), 0);
        en = 1'b1;
      end
      if (c == 7) begin
        chk("restart_s", int'(s), 0);
        chk("restart_valid", int'(s_valid), 1);
      end
    end
    do_reset();

    // mask drops to zero
    ch_mask = 4'b1000;
    dwell = 8'd1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) ch_mask = 4'b0000;
      if (c == 2) chk("zero_hold", int'(s_valid), 1);
      if (c == 3) begin
        chk("zero_sample", int'(sample), 4'b1000);
        chk("zero_valid", int'(s_valid), 0);
        chk("zero_nofd", int'(frame_done), 0);
      end
      if (c == 5) chk("zero_idle", int'(s_valid), 0);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(499) == 0) do_reset();
      if ($urandom_range(15) == 0)
        ch_mask = 4'($urandom_range(15));
      if ($urandom_range(15) == 0)
        dwell = 8'($urandom_range(4));
      en = ($urandom_range(19) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
